// File: rtl/div_pkg.sv
// Shared constants for the iterative restoring divider.
// State codes are plain localparams so legacy tools can use them too.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/iterative_divider_if.sv
// Request/response bundle for the divider.
// It uses the same valid-pulse handshake as the iterative multiplier.
interface iterative_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic               valid_in;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               valid_out;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   rem;
  logic               err;

  modport master (
    output valid_in, dividend, divisor,
    input  busy, valid_out, q, rem, err
  );

  modport slave (
    input  valid_in, dividend, divisor,
    output busy, valid_out, q, rem, err
  );

endinterface

// File: rtl/iterative_divider_step.sv
// One radix-2 restoring step: shift in the next dividend bit, then subtract if it fits.
// This is a separate module so it can be stacked later for higher radix.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] dExt;
  logic           fits;
  logic           unusedPMsb;

  // The partial remainder stays below D, so the MSB of P is always zero.
  assign unusedPMsb = p_i[WIDTH];

  assign trial = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign dExt  = {1'b0, d_i};
  assign fits  = (trial >= dExt);
  assign p_o   = fits ? (trial - dExt) : trial;
  assign q_o   = {q_i[WIDTH-2:0], fits};

endmodule

// File: rtl/iterative_divider.sv
// Sequential unsigned divider: a 2*WIDTH-bit dividend and a WIDTH-bit divisor give a quotient and a remainder.
// It resolves one quotient bit per clock and flags divide-by-zero or quotient overflow at accept time.
module iterative_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  iterative_divider_if.slave bus
);

  localparam int CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             errPend_q, errPend_d;
  logic [WIDTH-1:0] qOut_q, qOut_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             errOut_q, errOut_d;
  logic             validOut_q, validOut_d;

  logic [WIDTH:0]   pStep;
  logic [WIDTH-1:0] qStep;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i (p_q),
    .q_i (quo_q),
    .d_i (dvsr_q),
    .p_o (pStep),
    .q_o (qStep)
  );

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    errPend_d  = errPend_q;
    qOut_d     = qOut_q;
    remOut_d   = remOut_q;
    errOut_d   = errOut_q;
    validOut_d = 1'b0;

    // A new request always wins, which silently aborts any operation in flight.
    if (bus.valid_in) begin
      state_d   = RUN;
      p_d       = {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
      quo_d     = bus.dividend[WIDTH-1:0];
      dvsr_d    = bus.divisor;
      cnt_d     = '0;
      errPend_d = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
    end else begin
      case (state_q)
        RUN: begin
          if (errPend_q) begin
            state_d    = DONE;
            errPend_d  = 1'b0;
            validOut_d = 1'b1;
            errOut_d   = 1'b1;
            qOut_d     = '1;
            remOut_d   = quo_q;
          end else begin
            p_d   = pStep;
            quo_d = qStep;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastStep) begin
              state_d    = DONE;
              validOut_d = 1'b1;
              errOut_d   = 1'b0;
              qOut_d     = qStep;
              remOut_d   = pStep[WIDTH-1:0];
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p_q        <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      errPend_q  <= 1'b0;
      qOut_q     <= '0;
      remOut_q   <= '0;
      errOut_q   <= 1'b0;
      validOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      errPend_q  <= errPend_d;
      qOut_q     <= qOut_d;
      remOut_q   <= remOut_d;
      errOut_q   <= errOut_d;
      validOut_q <= validOut_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.valid_out = validOut_q;
  assign bus.q         = qOut_q;
  assign bus.rem       = remOut_q;
  assign bus.err       = errOut_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider.
// Directed corner cases are followed by randomized divides and multiply/divide round trips, all checked against an arithmetic reference.
module tb_iterative_divider;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  iterative_divider_if #(.WIDTH(W)) bus ();

  iterative_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: ordinary division, with overflow whenever the quotient cannot fit in W bits.
  task automatic refModel(input logic [63:0] dv, input logic [31:0] ds,
                          output logic [31:0] eq, output logic [31:0] er, output logic ee);
    logic [63:0] fullQ;
    logic [63:0] fullR;
    if (ds == 32'd0 || (dv / {32'd0, ds}) > 64'h0000_0000_FFFF_FFFF) begin
      ee = 1'b1;
      eq = 32'hFFFF_FFFF;
      er = dv[31:0];
    end else begin
      fullQ = dv / {32'd0, ds};
      fullR = dv % {32'd0, ds};
      ee = 1'b0;
      eq = fullQ[31:0];
      er = fullR[31:0];
    end
  endtask

  task automatic applyStimulus(input logic [63:0] dv, input logic [31:0] ds, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          expLat;
    refModel(dv, ds, eq, er, ee);
    expLat = ee ? 1 : W;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.dividend = dv;
    bus.divisor  = ds;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    checkOutput({tag, ".busyAfterAccept"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (bus.valid_out !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.valid_out !== 1'b1 && lat < expLat)
        checkOutput({tag, ".busyDuringRun"}, 64'(bus.busy), 64'd1);
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".q"},       64'(bus.q),    64'(eq));
    checkOutput({tag, ".rem"},     64'(bus.rem),  64'(er));
    checkOutput({tag, ".err"},     64'(bus.err),  64'(ee));
    checkOutput({tag, ".busyAtValid"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, ".pulseWidth"}, 64'(bus.valid_out), 64'd0);
    checkOutput({tag, ".qHold"},      64'(bus.q),         64'(eq));
  endtask

  initial begin
    int          pulses;
    int          firstLat;
    int          lat;
    logic [31:0] seenQ;
    logic [31:0] seenRem;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] dv;

    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset.valid_out", 64'(bus.valid_out), 64'd0);
    checkOutput("reset.busy",      64'(bus.busy),      64'd0);
    checkOutput("reset.q",         64'(bus.q),         64'd0);
    checkOutput("reset.rem",       64'(bus.rem),       64'd0);
    checkOutput("reset.err",       64'(bus.err),       64'd0);

    $display("[TB] directed cases");
    applyStimulus(64'd100, 32'd7, "basic");
    applyStimulus(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, "max");
    applyStimulus(64'd5, 32'd0, "divByZero");
    applyStimulus(64'h1_0000_0000, 32'd1, "overflow");
    applyStimulus(64'h0000_0006_0000_0000, 32'd7, "highBelowDivisor");
    applyStimulus(64'd0, 32'd3, "zeroDividend");

    $display("[TB] restart mid-run");
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.dividend = 64'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.dividend = 64'd1000;
    bus.divisor  = 32'd10;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    pulses   = 0;
    firstLat = -1;
    seenQ    = '0;
    seenRem  = '1;
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out === 1'b1) begin
        pulses++;
        if (firstLat < 0) begin
          firstLat = lat;
          seenQ    = bus.q;
          seenRem  = bus.rem;
        end
      end
    end
    checkOutput("restart.pulses",  64'(pulses),   64'd1);
    checkOutput("restart.latency", 64'(firstLat), 64'(W));
    checkOutput("restart.q",       64'(seenQ),    64'd100);
    checkOutput("restart.rem",     64'(seenRem),  64'd0);

    $display("[TB] reset mid-run");
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.dividend = 64'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.valid_out", 64'(bus.valid_out), 64'd0);
    checkOutput("midReset.busy",      64'(bus.busy),      64'd0);
    checkOutput("midReset.q",         64'(bus.q),         64'd0);
    checkOutput("midReset.rem",       64'(bus.rem),       64'd0);
    checkOutput("midReset.err",       64'(bus.err),       64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.valid_out === 1'b1) pulses++;
    end
    checkOutput("midReset.noPulse", 64'(pulses), 64'd0);

    $display("[TB] random divides");
    for (int i = 0; i < 60; i++) begin
      b  = $urandom;
      if (i % 10 == 0) b = 32'd0;
      dv = {32'($urandom), 32'($urandom)};
      if (i % 3 != 0 && b != 32'd0) dv[63:32] = dv[63:32] % b;
      applyStimulus(dv, b, "random");
    end

    $display("[TB] multiply/divide round trip");
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = $urandom_range(255, 1);
      if (b == 32'd0) b = 32'd1;
      dv = 64'(a) * 64'(b);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.dividend = dv;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      lat = 0;
      while (bus.valid_out !== 1'b1 && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput("roundTrip.latency", 64'(lat),     64'(W));
      checkOutput("roundTrip.q",       64'(bus.q),   64'(a));
      checkOutput("roundTrip.rem",     64'(bus.rem), 64'd0);
      checkOutput("roundTrip.err",     64'(bus.err), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
